// File: rtl/cmp_result_collector.sv
// -----------------------------------------------------------------------------
// cmp_result_collector
//
// Sits behind the 32-bit comparator. It follows every compare issued to the
// comparator through a LAT-deep valid/tag delay line. When an entry reaches the
// end of the line, it samples the comparator's registered flags and encodes
// them into a 2-bit result. It then pushes {tag, result} into a small
// valid/ready FIFO. Credits are handed back to the issuing stage so that a
// capture always finds room in the FIFO. Saturating per-result counters and a
// sticky error flag for impossible flag patterns are kept alongside.
//
// Ports
//   clk          clock shared with the comparator
//   resetn       asynchronous active-low reset
//   issue_valid  a compare is presented to the comparator this cycle
//   issue_tag    tag of that compare
//   issue_ready  a compare may be issued this cycle (credit available)
//   eq/neq/grt/lss  registered comparator flags
//   rsp_valid    FIFO head valid
//   rsp_ready    consumer accepts the head
//   rsp_tag      tag at the FIFO head
//   rsp_res      result at the FIFO head: 00 EQ, 01 LT, 10 GT, 11 INVALID
//   cnt_eq/lt/gt saturating counts of results pushed into the FIFO
//   cnt_clr      synchronous clear of the three counters (wins over increment)
//   err          sticky, set when an INVALID flag pattern is captured
// -----------------------------------------------------------------------------
module cmp_result_collector #(
    parameter int TAG_W = 4,
    parameter int LAT   = 1,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             issue_ready,
    input  logic             eq,
    input  logic             neq,
    input  logic             grt,
    input  logic             lss,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_res,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] cnt_gt,
    input  logic             cnt_clr,
    output logic             err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    // Room for FIFO occupancy plus up to four in-flight compares.
    localparam int SUM_W = OCC_W + 3;

    localparam logic [1:0] RES_EQ  = 2'b00;
    localparam logic [1:0] RES_LT  = 2'b01;
    localparam logic [1:0] RES_GT  = 2'b10;
    localparam logic [1:0] RES_INV = 2'b11;

    // Only the three one-hot-consistent flag patterns are legal results.
    function automatic logic [1:0] enc_flags(input logic f_eq, input logic f_neq,
                                             input logic f_grt, input logic f_lss);
        case ({f_eq, f_neq, f_grt, f_lss})
            4'b1000: return RES_EQ;
            4'b0101: return RES_LT;
            4'b0110: return RES_GT;
            default: return RES_INV;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [LAT-1:0]     vld_p;
    logic [TAG_W-1:0]   tag_p [LAT];
    logic [TAG_W+1:0]   mem   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [SUM_W-1:0]   inflight;
    logic [SUM_W-1:0]   credit_used;
    logic [TAG_W+1:0]   head;
    logic [1:0]         cap_res;
    logic               issue_fire;
    logic               push;
    logic               pop;

    // Credits count both stored entries and compares still in the delay line,
    // so every capture is guaranteed a free FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + SUM_W'(vld_p[i]);
        end
        credit_used = SUM_W'(occ) + inflight;
        issue_ready = credit_used < SUM_W'(DEPTH);
    end

    assign issue_fire = issue_valid & issue_ready;
    assign push       = vld_p[LAT-1];
    assign cap_res    = enc_flags(eq, neq, grt, lss);
    assign rsp_valid  = (occ != '0);
    assign pop        = rsp_valid & rsp_ready;

    // ---- issue -> delay line: stage 0 loads on accept, stages shift each edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue_fire;
            for (int i = 1; i < LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_p[0] <= issue_tag;
        for (int i = 1; i < LAT; i++) begin
            tag_p[i] <= tag_p[i-1];
        end
    end

    // ---- delay line -> FIFO: capture flags with the tag at the end of the line
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tag_p[LAT-1], cap_res};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // ---- FIFO head -> consumer: outputs read as zero while the FIFO is empty
    assign head    = mem[rd_ptr];
    assign rsp_tag = rsp_valid ? head[TAG_W+1:2] : '0;
    assign rsp_res = rsp_valid ? head[1:0] : 2'b00;

    // ---- statistics and sticky error, updated on each push
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_eq <= '0;
            cnt_lt <= '0;
            cnt_gt <= '0;
        end else if (cnt_clr) begin
            cnt_eq <= '0;
            cnt_lt <= '0;
            cnt_gt <= '0;
        end else if (push) begin
            case (cap_res)
                RES_EQ:  cnt_eq <= sat_inc(cnt_eq);
                RES_LT:  cnt_lt <= sat_inc(cnt_lt);
                RES_GT:  cnt_gt <= sat_inc(cnt_gt);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (push && (cap_res == RES_INV)) begin
            err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // The credit scheme should make this unreachable; a hit means the issuing
    // stage ignored issue_ready.
    capture_into_full_a : assert property (@(posedge clk) disable iff (!resetn)
        !(push && !pop && (occ == OCC_W'(DEPTH))))
        else $error("capture into full result FIFO");
`endif

endmodule

// File: tb/tb_cmp_result_collector.sv
module tb_cmp_result_collector;

    localparam int TAG_W = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    localparam logic [1:0] R_EQ  = 2'b00;
    localparam logic [1:0] R_LT  = 2'b01;
    localparam logic [1:0] R_GT  = 2'b10;
    localparam logic [1:0] R_INV = 2'b11;

    logic             clk;
    logic             resetn;
    logic             issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_ready;
    logic             eq, neq, grt, lss;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       rsp_res;
    logic [CNT_W-1:0] cnt_eq, cnt_lt, cnt_gt;
    logic             cnt_clr;
    logic             err;

    // comparator operands driven by the bench
    logic [31:0] op1, op2;
    logic        sgn;
    logic        cmp_bad;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [1:0]       res;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    cmp_result_collector #(
        .TAG_W(TAG_W), .LAT(LAT), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .issue_valid(issue_valid),
        .issue_tag  (issue_tag),
        .issue_ready(issue_ready),
        .eq         (eq),
        .neq        (neq),
        .grt        (grt),
        .lss        (lss),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_tag    (rsp_tag),
        .rsp_res    (rsp_res),
        .cnt_eq     (cnt_eq),
        .cnt_lt     (cnt_lt),
        .cnt_gt     (cnt_gt),
        .cnt_clr    (cnt_clr),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered comparator with one cycle of latency; cmp_bad forces the
    // illegal eq+grt pattern.
    always @(posedge clk) begin
        if (cmp_bad) begin
            {eq, neq, grt, lss} <= 4'b1010;
        end else begin
            eq  <= (op1 == op2);
            neq <= (op1 != op2);
            grt <= sgn ? ($signed(op1) > $signed(op2)) : (op1 > op2);
            lss <= sgn ? ($signed(op1) < $signed(op2)) : (op1 < op2);
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Scoreboard monitor: compares the head on every cycle a handshake will occur.
    always @(negedge clk) begin
        if (resetn && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_rsp: got tag=%0d res=%0d, expected no response",
                         rsp_tag, rsp_res);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_tag", rsp_tag, e.tag);
                check("rsp_res", rsp_res, e.res);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [TAG_W-1:0] tag, input logic [31:0] a,
                            input logic [31:0] b, input logic s, input logic bad,
                            input logic [1:0] res);
        int   waited;
        exp_t e;
        waited      = 0;
        issue_valid = 1'b1;
        issue_tag   = tag;
        op1         = a;
        op2         = b;
        sgn         = s;
        cmp_bad     = bad;
        forever begin
            @(negedge clk);
            if (issue_ready) begin
                e.tag = tag;
                e.res = res;
                exp_q.push_back(e);
                break;
            end
            waited++;
            if (waited > 50) begin
                total++;
                $display("FAIL issue_timeout: tag %0d not accepted, expected acceptance", tag);
                break;
            end
            @(posedge clk);
        end
        tick();
        issue_valid = 1'b0;
        cmp_bad     = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        tick();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int accepts;
        int saw;
        resetn      = 1'b0;
        issue_valid = 1'b0;
        issue_tag   = '0;
        rsp_ready   = 1'b0;
        cnt_clr     = 1'b0;
        op1         = '0;
        op2         = '0;
        sgn         = 1'b0;
        cmp_bad     = 1'b0;
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        tick();

        // reset state
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_rsp_res", rsp_res, 0);
        check("rst_cnt_eq", cnt_eq, 0);
        check("rst_cnt_lt", cnt_lt, 0);
        check("rst_cnt_gt", cnt_gt, 0);
        check("rst_err", err, 0);
        check("rst_issue_ready", issue_ready, 1);

        // single EQ compare, latency
        rsp_ready = 1'b1;
        do_issue(4'd3, 32'd5, 32'd5, 1'b0, 1'b0, R_EQ);
        check("lat_edge1_valid", rsp_valid, 0);
        tick();
        check("lat_edge2_valid", rsp_valid, 1);
        check("t1_cnt_eq", cnt_eq, 1);
        drain("t1_drain");

        // signed vs unsigned on the same operands
        do_issue(4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, R_LT);
        do_issue(4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, R_GT);
        drain("t2_drain");
        check("t2_cnt_lt", cnt_lt, 1);
        check("t2_cnt_gt", cnt_gt, 1);

        // credit backpressure with consumer stalled
        rsp_ready   = 1'b0;
        accepts     = 0;
        issue_valid = 1'b1;
        op1         = 32'd9;
        op2         = 32'd9;
        sgn         = 1'b0;
        for (int c = 0; c < 8; c++) begin
            exp_t e;
            issue_tag = TAG_W'(accepts);
            @(negedge clk);
            if (issue_ready) begin
                e.tag = TAG_W'(accepts);
                e.res = R_EQ;
                exp_q.push_back(e);
                accepts++;
            end
            tick();
        end
        issue_valid = 1'b0;
        check("credit_accepts", accepts, DEPTH);
        check("credit_ready_low", issue_ready, 0);
        check("credit_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        check("credit_ready_after_pop", issue_ready, 1);
        drain("t3_drain");
        check("t3_cnt_eq", cnt_eq, 5);

        // invalid flag pattern
        do_issue(4'd5, 32'd1, 32'd2, 1'b0, 1'b1, R_INV);
        drain("t4_inv_drain");
        check("inv_err", err, 1);
        check("inv_cnt_eq", cnt_eq, 5);
        check("inv_cnt_lt", cnt_lt, 1);
        check("inv_cnt_gt", cnt_gt, 1);
        for (int i = 0; i < 10; i++) begin
            do_issue(TAG_W'(i), 32'hFFFF_FFFD, 32'd4, 1'b1, 1'b0, R_LT);
        end
        drain("t4_lt_drain");
        check("err_sticky", err, 1);
        check("t4_cnt_lt", cnt_lt, 11);

        // clear, saturation, clear beats increment
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_cnt_eq", cnt_eq, 0);
        check("clr_cnt_lt", cnt_lt, 0);
        check("clr_cnt_gt", cnt_gt, 0);
        for (int i = 0; i < 15; i++) begin
            do_issue(TAG_W'(i), 32'd100, 32'd7, 1'b0, 1'b0, R_GT);
        end
        drain("t5_fill_drain");
        check("sat_cnt_gt_15", cnt_gt, 15);
        do_issue(4'd15, 32'd100, 32'd7, 1'b0, 1'b0, R_GT);
        drain("t5_sat_drain");
        check("sat_cnt_gt_hold", cnt_gt, 15);
        do_issue(4'd1, 32'd100, 32'd7, 1'b0, 1'b0, R_GT);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_priority_cnt_gt", cnt_gt, 0);
        drain("t5_clr_drain");

        // reset with 2 entries stored and 1 in flight
        rsp_ready = 1'b0;
        do_issue(4'd10, 32'd3, 32'd3, 1'b0, 1'b0, R_EQ);
        do_issue(4'd11, 32'd3, 32'd3, 1'b0, 1'b0, R_EQ);
        do_issue(4'd12, 32'd3, 32'd3, 1'b0, 1'b0, R_EQ);
        check("pre_rst_cnt_eq", cnt_eq, 2);
        check("pre_rst_rsp_valid", rsp_valid, 1);
        check("pre_rst_err", err, 1);
        #2 resetn = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cnt_eq", cnt_eq, 0);
        check("mid_rst_cnt_lt", cnt_lt, 0);
        check("mid_rst_cnt_gt", cnt_gt, 0);
        check("mid_rst_err", err, 0);
        #2 resetn = 1'b1;
        rsp_ready = 1'b1;
        saw = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) saw = 1;
        end
        check("post_rst_no_rsp", saw, 0);
        check("post_rst_issue_ready", issue_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
